// File: rtl/prog_blinker_ctrl.sv
// Programmable-rate blinker channel: edge-detected rate shifts and a tick counter against H(k).
// Optional BLINK_RATE_WRAP_EN makes the rate index wrap at both ends instead of saturating.
module prog_blinker_ctrl #(
  parameter int NUM_RATES  = 4,
  parameter int BASE_HALF  = 2,
  parameter int CNT_W      = 5,
  parameter int IDX_W      = 2,
  parameter int RESET_RATE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic             shift_left,
  input  logic             shift_right,
  output logic             blink_out,
  output logic [IDX_W-1:0] rate_idx,
  output logic             toggle_pulse
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_RATES - 1);
  localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(RESET_RATE);
  localparam logic [CNT_W-1:0] BASE_H  = CNT_W'(BASE_HALF);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
  logic             pulse_q, pulse_d;
  logic             shl_q, shr_q;

  logic             ev_l, ev_r;
  logic             rate_chg;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] half_m1;

  assign ev_l = shift_left  & ~shl_q;
  assign ev_r = shift_right & ~shr_q;

  assign half    = BASE_H << idx_q;
  assign half_m1 = half - CNT_W'(1);

  // Simultaneous left/right edges cancel and are not a rate change.
  always_comb begin
    idx_d    = idx_q;
    rate_chg = 1'b0;
    if (ev_r && !ev_l) begin
      if (idx_q != '0) begin
        idx_d    = idx_q - IDX_W'(1);
        rate_chg = 1'b1;
      end
`ifdef BLINK_RATE_WRAP_EN
      else begin
        idx_d    = MAX_IDX;
        rate_chg = 1'b1;
      end
`endif
    end else if (ev_l && !ev_r) begin
      if (idx_q != MAX_IDX) begin
        idx_d    = idx_q + IDX_W'(1);
        rate_chg = 1'b1;
      end
`ifdef BLINK_RATE_WRAP_EN
      else begin
        idx_d    = '0;
        rate_chg = 1'b1;
      end
`endif
    end
  end

  // Disable dominates; a rate change restarts the period and swallows a coincident tick.
  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    pulse_d = 1'b0;
    if (!enable) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (rate_chg) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == half_m1) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= RST_IDX;
      cnt_q   <= '0;
      blink_q <= 1'b0;
      pulse_q <= 1'b0;
      shl_q   <= 1'b0;
      shr_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      pulse_q <= pulse_d;
      shl_q   <= shift_left;
      shr_q   <= shift_right;
    end
  end

  assign blink_out    = blink_q;
  assign rate_idx     = idx_q;
  assign toggle_pulse = pulse_q;

endmodule

// File: tb/tb_prog_blinker_ctrl.sv
// Directed bench for prog_blinker_ctrl (default build: saturating rate index).
module tb_prog_blinker_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       tick;
  logic       shift_left;
  logic       shift_right;
  logic       blink_out;
  logic [1:0] rate_idx;
  logic       toggle_pulse;

  int n_tot = 0;
  int n_bad = 0;

  prog_blinker_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tick         (tick),
    .shift_left   (shift_left),
    .shift_right  (shift_right),
    .blink_out    (blink_out),
    .rate_idx     (rate_idx),
    .toggle_pulse (toggle_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tot++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tick = 1'b0; shift_left = 1'b0; shift_right = 1'b0;
    #1;
    chk("rst_rate",  32'(rate_idx), 32'd2);
    chk("rst_blink", 32'(blink_out), 32'd0);
    chk("rst_pulse", 32'(toggle_pulse), 32'd0);
    @(negedge clk);
    @(negedge clk);

    // Defaults, tick held high: H=8, rise after edge 8, fall after edge 16
    reset = 1'b0; enable = 1'b1; tick = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      step();
      chk("def_blink", 32'(blink_out), 32'((n >= 8) && (n < 16)));
      chk("def_pulse", 32'(toggle_pulse), 32'((n == 8) || (n == 16)));
      chk("def_rate",  32'(rate_idx), 32'd2);
    end

    // shift_right held: one step to k=1, then H=4
    shift_right = 1'b1;
    step();
    chk("shr_rate0", 32'(rate_idx), 32'd1);
    for (int j = 1; j <= 9; j++) begin
      step();
      chk("shr_rate",  32'(rate_idx), 32'd1);
      chk("shr_blink", 32'(blink_out), 32'((j >= 4) && (j < 8)));
      chk("shr_pulse", 32'(toggle_pulse), 32'((j == 4) || (j == 8)));
    end
    shift_right = 1'b0;

    // Back to k=2, then three left pulses; only the first clears cnt
    tick = 1'b0; shift_left = 1'b1;
    step();
    chk("shl_k2", 32'(rate_idx), 32'd2);
    shift_left = 1'b0;
    step();
    shift_left = 1'b1;
    step();
    chk("shl_p1", 32'(rate_idx), 32'd3);
    shift_left = 1'b0; tick = 1'b1;
    steps(3);
    shift_left = 1'b1;
    step();
    chk("shl_p2", 32'(rate_idx), 32'd3);
    shift_left = 1'b0;
    step();
    shift_left = 1'b1;
    step();
    chk("shl_p3", 32'(rate_idx), 32'd3);
    shift_left = 1'b0;
    steps(9);
    chk("shl_cnt_pre",  32'(blink_out), 32'd0);
    step();
    chk("shl_cnt_tog",  32'(blink_out), 32'd1);
    chk("shl_cnt_puls", 32'(toggle_pulse), 32'd1);

    // Both edges together with tick at cnt=7, k=2
    tick = 1'b0; shift_right = 1'b1;
    step();
    chk("both_k2",     32'(rate_idx), 32'd2);
    chk("both_keep",   32'(blink_out), 32'd1);
    shift_right = 1'b0;
    step();
    tick = 1'b1;
    steps(7);
    shift_left = 1'b1; shift_right = 1'b1;
    step();
    chk("both_rate",  32'(rate_idx), 32'd2);
    chk("both_blink", 32'(blink_out), 32'd0);
    chk("both_pulse", 32'(toggle_pulse), 32'd1);
    shift_left = 1'b0; shift_right = 1'b0; tick = 1'b0;
    step();
    chk("both_pulse_off", 32'(toggle_pulse), 32'd0);
    tick = 1'b1;
    steps(7);
    chk("both_cnt_pre", 32'(blink_out), 32'd0);
    step();
    chk("both_cnt_tog", 32'(blink_out), 32'd1);

    // Right edge coinciding with tick at cnt=7: rate change wins
    steps(7);
    shift_right = 1'b1;
    step();
    chk("rc_rate",  32'(rate_idx), 32'd1);
    chk("rc_blink", 32'(blink_out), 32'd1);
    chk("rc_pulse", 32'(toggle_pulse), 32'd0);
    shift_right = 1'b0;
    steps(3);
    chk("rc_cnt_pre", 32'(blink_out), 32'd1);
    step();
    chk("rc_cnt_tog", 32'(blink_out), 32'd0);
    chk("rc_cnt_pls", 32'(toggle_pulse), 32'd1);

    tick = 1'b0; shift_left = 1'b1;
    step();
    chk("ret_k2", 32'(rate_idx), 32'd2);
    shift_left = 1'b0;
    step();

    // Enable dropped at cnt=5 while high, then re-enabled
    tick = 1'b1;
    steps(8);
    chk("en_hi", 32'(blink_out), 32'd1);
    steps(5);
    enable = 1'b0;
    step();
    chk("en_off_blink", 32'(blink_out), 32'd0);
    chk("en_off_pulse", 32'(toggle_pulse), 32'd0);
    step();
    chk("en_off_hold", 32'(blink_out), 32'd0);
    enable = 1'b1;
    steps(7);
    chk("en_re_pre", 32'(blink_out), 32'd0);
    step();
    chk("en_re_tog", 32'(blink_out), 32'd1);
    chk("en_re_pls", 32'(toggle_pulse), 32'd1);

    // Asynchronous reset mid-period at cnt=3, k=3
    tick = 1'b0; shift_left = 1'b1;
    step();
    chk("ar_k3", 32'(rate_idx), 32'd3);
    shift_left = 1'b0; tick = 1'b1;
    steps(3);
    #2 reset = 1'b1;
    #1;
    chk("ar_rate",  32'(rate_idx), 32'd2);
    chk("ar_blink", 32'(blink_out), 32'd0);
    chk("ar_pulse", 32'(toggle_pulse), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    steps(7);
    chk("ar_post_pre", 32'(blink_out), 32'd0);
    step();
    chk("ar_post_tog", 32'(blink_out), 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
